// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: CPU datapath and debug/loader port.
// Define MEM_ARB_RR_EN for strict round-robin; default is CPU priority with debug starvation guard.
module mem_arbiter #(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [3:0]    cpu_be,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [3:0]    dbg_be,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_done,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 1 = debug port
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          arb_ok, dbg_win, grant;
`ifdef MEM_ARB_RR_EN
    logic          last_q, last_d;     // 1 = debug was granted last
`else
    logic [3:0]    starve_q, starve_d;
`endif

    always_comb begin
        arb_ok = (state_q != ACC) && !rst;
`ifdef MEM_ARB_RR_EN
        dbg_win = dbg_req && (!cpu_req || !last_q);
`else
        dbg_win = dbg_req && (!cpu_req || (starve_q == 4'(STARVE_MAX)));
`endif
        cpu_gnt = arb_ok && cpu_req && !dbg_win;
        dbg_gnt = arb_ok && dbg_win;
        grant   = cpu_gnt || dbg_gnt;

        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            ACC: begin
                state_d = RSP;
                if (!we_q) begin
                    if (owner_q) dbg_rdata_d = mem_rdata;
                    else         cpu_rdata_d = mem_rdata;
                end
            end
            default: state_d = grant ? ACC : IDLE;
        endcase

        if (grant) begin
            owner_d = dbg_gnt;
            we_d    = dbg_gnt ? dbg_we    : cpu_we;
            addr_d  = dbg_gnt ? dbg_addr  : cpu_addr;
            be_d    = dbg_gnt ? dbg_be    : cpu_be;
            wdata_d = dbg_gnt ? dbg_wdata : cpu_wdata;
        end

`ifdef MEM_ARB_RR_EN
        last_d = grant ? dbg_gnt : last_q;
`else
        // Counts CPU wins against a waiting debug request; any debug win or idle debug port clears it.
        starve_d = starve_q;
        if (!dbg_req || dbg_gnt)
            starve_d = '0;
        else if (cpu_gnt && starve_q != 4'(STARVE_MAX))
            starve_d = starve_q + 4'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b1;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    // Memory bus is quiet (all zero) outside ACC; reset suppresses an in-flight write and done.
    assign mem_en    = (state_q == ACC);
    assign mem_we    = mem_en && we_q && !rst;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_be    = mem_en ? be_q    : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign cpu_done  = (state_q == RSP) && !owner_q && !rst;
    assign dbg_done  = (state_q == RSP) &&  owner_q && !rst;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic checked every cycle
// against a transaction-level model (grant policy, 2-cycle access timing, shadow memory).
module tb_mem_arbiter;

    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [3:0]    cpu_be, dbg_be, mem_be;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
    logic          cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, mem_we, busy;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT
    logic [DW-1:0] mem [0:31];
    assign mem_rdata = mem[mem_addr[4:0]];
    always @(posedge clk)
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: an access occupies the grant cycle plus two more (access, response);
    // a new grant may coincide with the response cycle.
    logic [DW-1:0] sh [0:31];
    int            m_age;        // 0 = no access, 1 = access cycle, 2 = response cycle
    bit            m_own_dbg, m_we, m_last_dbg;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [DW-1:0] m_wd, m_cpu_rd, m_dbg_rd;
    int            m_cnt;
    bit            g_cpu, g_dbg;

    task automatic model_reset();
        m_age = 0; m_own_dbg = 0; m_we = 0; m_last_dbg = 1; m_cnt = 0;
        m_cpu_rd = '0; m_dbg_rd = '0;
    endtask

    task automatic model_step();
        bit acc, rsp, any, wdbg;
        g_cpu = cpu_gnt; g_dbg = dbg_gnt;
        acc = (m_age == 1); rsp = (m_age == 2);
        if (rst) begin
            chk("rst_cpu_gnt", cpu_gnt, 0);
            chk("rst_dbg_gnt", dbg_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            model_reset();
            return;
        end
        any = !acc && (cpu_req || dbg_req);
`ifdef MEM_ARB_RR_EN
        wdbg = dbg_req && (!cpu_req || !m_last_dbg);
`else
        wdbg = dbg_req && (!cpu_req || m_cnt >= SMAX);
`endif
        chk("cpu_gnt", cpu_gnt, any && !wdbg);
        chk("dbg_gnt", dbg_gnt, any && wdbg);
        chk("mem_en", mem_en, acc);
        chk("mem_we", mem_we, acc && m_we);
        if (acc) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wd);
        end
        chk("cpu_done", cpu_done, rsp && !m_own_dbg);
        chk("dbg_done", dbg_done, rsp && m_own_dbg);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("dbg_rdata", dbg_rdata, m_dbg_rd);
        chk("busy", busy, m_age != 0);

        if (acc) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) sh[m_addr[4:0]][8*b +: 8] = m_wd[8*b +: 8];
            end else if (m_own_dbg) m_dbg_rd = sh[m_addr[4:0]];
            else                    m_cpu_rd = sh[m_addr[4:0]];
            m_age = 2;
        end else if (any) begin
            m_own_dbg = wdbg;
            m_we   = wdbg ? dbg_we    : cpu_we;
            m_addr = wdbg ? dbg_addr  : cpu_addr;
            m_be   = wdbg ? dbg_be    : cpu_be;
            m_wd   = wdbg ? dbg_wdata : cpu_wdata;
            m_last_dbg = wdbg;
            m_age = 1;
            if (wdbg) m_cnt = 0;
            else if (dbg_req && m_cnt < SMAX) m_cnt++;
        end else m_age = 0;
        if (!dbg_req) m_cnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit dbg, input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] wd);
        if (dbg) begin dbg_req = req; dbg_we = we; dbg_addr = a; dbg_be = be; dbg_wdata = wd; end
        else     begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd; end
    endtask

    // One complete access from an idle arbiter; leaves the arbiter idle again.
    task automatic issue(input bit dbg, input bit we, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] wd);
        bit got = 0;
        drive(dbg, 1, we, a, be, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = dbg ? g_dbg : g_cpu;
        end
        if (!got) chk("issue_timeout", 0, 1);
        drive(dbg, 0, 0, '0, '0, '0);
        tick(); tick();
    endtask

    bit seq [$];

    initial begin
        model_reset();
        for (int i = 0; i < 32; i++) sh[i] = '0;
        rst = 1;
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;

        // Reset state
        chk("rst_cpu_gnt0", cpu_gnt, 0);   chk("rst_dbg_gnt0", dbg_gnt, 0);
        chk("rst_cpu_done", cpu_done, 0);  chk("rst_dbg_done", dbg_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_mem_en", mem_en, 0);      chk("rst_mem_we0", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_busy", busy, 0);

        // Preload through the loader port, then CPU read
        issue(1, 1, 30'h10, 4'hF, 32'hDEADBEEF);
        issue(0, 0, 30'h10, 4'h0, 32'h0);
        chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // Partial-byte write, wdata never echoed on rdata
        issue(1, 1, 30'h3, 4'hF, 32'hFFFFFFFF);
        issue(1, 1, 30'h3, 4'b0011, 32'h12345678);
        chk("t2_dbg_rdata_hold", dbg_rdata, 32'h0);
        issue(0, 0, 30'h3, 4'h0, 32'h0);
        chk("t2_rdata", cpu_rdata, 32'hFFFF5678);

        // Back-to-back CPU reads with req held
        drive(0, 1, 0, 30'h10, 4'h0, 32'h0);
        tick();
        chk("t4_gnt1", g_cpu, 1);
        drive(0, 1, 0, 30'h3, 4'h0, 32'h0);
        tick(); tick();
        chk("t4_gnt2", g_cpu, 1);
        chk("t4_rd1", cpu_rdata, 32'hDEADBEEF);
        drive(0, 0, 0, '0, '0, '0);
        tick(); tick();
        chk("t4_rd2", cpu_rdata, 32'hFFFF5678);
        tick();

        // Both ports held: grant order
        drive(0, 1, 0, 30'h10, 4'h0, 32'h0);
        drive(1, 1, 0, 30'h3, 4'h0, 32'h0);
        for (int i = 0; i < 60 && seq.size() < 10; i++) begin
            tick();
            if (g_cpu) seq.push_back(1'b0);
            if (g_dbg) seq.push_back(1'b1);
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        tick(); tick(); tick();
        chk("t3_count", seq.size(), 10);
        for (int k = 0; k < seq.size() && k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("t3_order%0d", k), seq[k], (k % 2) == 0);
`else
            chk($sformatf("t3_order%0d", k), seq[k], (k % (SMAX + 1)) == SMAX);
`endif
        end

        // Idle period
        for (int i = 0; i < 10; i++) tick();

        // Fill the random window, then random traffic on both ports
        for (int a = 0; a < 16; a++) issue(1, 1, 30'(a), 4'hF, $urandom);
        for (int i = 0; i < 400; i++) begin
            if ((cpu_req && g_cpu) || !cpu_req) begin
                if ($urandom_range(0, 2) != 0)
                    drive(0, 1, $urandom_range(0, 1), 30'($urandom_range(0, 15)), 4'($urandom), $urandom);
                else drive(0, 0, 0, '0, '0, '0);
            end
            if ((dbg_req && g_dbg) || !dbg_req) begin
                if ($urandom_range(0, 2) != 0)
                    drive(1, 1, $urandom_range(0, 1), 30'($urandom_range(0, 15)), 4'($urandom), $urandom);
                else drive(1, 0, 0, '0, '0, '0);
            end
            tick();
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        tick(); tick(); tick();

        // Reset during the access cycle of a CPU write
        drive(0, 1, 1, 30'h5, 4'hF, 32'hA5A5A5A5);
        tick();
        chk("t5_gnt", g_cpu, 1);
        drive(0, 0, 0, '0, '0, '0);
        rst = 1;
        @(negedge clk);
        chk("t5_mem_we", mem_we, 0);
        model_step();
        @(posedge clk); #1;
        rst = 0;
        chk("t5_done", cpu_done, 0);  chk("t5_busy", busy, 0);
        chk("t5_mem_en", mem_en, 0);  chk("t5_rdata", cpu_rdata, 0);
        chk("t5_mem_addr", mem_addr, 0);
        tick();
        issue(0, 0, 30'h5, 4'h0, 32'h0);
        chk("t5_unwritten", cpu_rdata, sh[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
